// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one FP multiplier core among N requesters,
// carries one operation at a time and guards the core with a watchdog.
module fp_mul_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      i_req_valid,
  input  logic [32*N-1:0]   i_req_op1,
  input  logic [32*N-1:0]   i_req_op2,
  output logic [N-1:0]      o_req_accept,
  output logic [N-1:0]      o_resp_valid,
  output logic [31:0]       o_resp_res,
  output logic [IDW-1:0]    o_resp_id,
  output logic              o_mul_ready,
  output logic [31:0]       o_mul_op1,
  output logic [31:0]       o_mul_op2,
  input  logic [31:0]       i_mul_res,
  input  logic              i_mul_done,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state, w_nextState;
  logic [IDW-1:0]  r_last, r_id;
  logic [CW-1:0]   r_count;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [31:0]     w_selOp1, w_selOp2;
  logic            w_timeoutHit;

  logic [N-1:0]    w_acceptNext, w_respValidNext;
  logic [31:0]     w_respResNext, w_op1Next, w_op2Next;
  logic [IDW-1:0]  w_respIdNext, w_idNext, w_lastNext;
  logic [CW-1:0]   w_countNext;
  logic            w_readyNext, w_timeoutNext;

  // Round robin: first requester above the last grant, then wrap to the bottom.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req_valid[i] && (i > int'(r_last))) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req_valid[i] && (i <= int'(r_last))) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
  end

  always_comb begin
    w_selOp1 = '0;
    w_selOp2 = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == w_winner) begin
        w_selOp1 = i_req_op1[32*i +: 32];
        w_selOp2 = i_req_op2[32*i +: 32];
      end
    end
  end

  assign w_timeoutHit = (r_count == CW'(TIMEOUT-1));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (i_mul_done || w_timeoutHit) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A done pulse in the timeout cycle takes precedence over the watchdog.
  always_comb begin
    w_acceptNext    = '0;
    w_readyNext     = 1'b0;
    w_respValidNext = '0;
    w_respResNext   = o_resp_res;
    w_respIdNext    = o_resp_id;
    w_op1Next       = o_mul_op1;
    w_op2Next       = o_mul_op2;
    w_idNext        = r_id;
    w_lastNext      = r_last;
    w_countNext     = r_count;
    w_timeoutNext   = o_timeout_err;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_acceptNext = {{(N-1){1'b0}}, 1'b1} << w_winner;
          w_readyNext  = 1'b1;
          w_op1Next    = w_selOp1;
          w_op2Next    = w_selOp2;
          w_idNext     = w_winner;
          w_lastNext   = w_winner;
        end
      end
      ISSUE: w_countNext = '0;
      WAIT: begin
        w_countNext = r_count + 1'b1;
        if (i_mul_done) begin
          w_respValidNext = {{(N-1){1'b0}}, 1'b1} << r_id;
          w_respResNext   = i_mul_res;
          w_respIdNext    = r_id;
        end else if (w_timeoutHit) begin
          w_timeoutNext   = 1'b1;
          w_respValidNext = {{(N-1){1'b0}}, 1'b1} << r_id;
          w_respResNext   = 32'h7FFF_FFFF;
          w_respIdNext    = r_id;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last        <= IDW'(N-1);
      r_id          <= '0;
      r_count       <= '0;
      o_req_accept  <= '0;
      o_resp_valid  <= '0;
      o_resp_res    <= '0;
      o_resp_id     <= '0;
      o_mul_ready   <= 1'b0;
      o_mul_op1     <= '0;
      o_mul_op2     <= '0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_last        <= w_lastNext;
      r_id          <= w_idNext;
      r_count       <= w_countNext;
      o_req_accept  <= w_acceptNext;
      o_resp_valid  <= w_respValidNext;
      o_resp_res    <= w_respResNext;
      o_resp_id     <= w_respIdNext;
      o_mul_ready   <= w_readyNext;
      o_mul_op1     <= w_op1Next;
      o_mul_op2     <= w_op2Next;
      o_busy        <= (w_nextState != IDLE);
      o_timeout_err <= w_timeoutNext;
    end
  end

endmodule
